bufr_mmcme: RTL and testbench

//  Fabric clock divider that emulates a BUFR/MMCM divided clock output.

---
 rtl/bufr_mmcme.sv | 71 +++++++
 tb/tb_bufr_mmcme.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bufr_mmcme.sv
// bufr_mmcme: fabric clock divider, out = clk / DIVISOR, phase anchored to reset release.
// Defining BUFR_MMCME_LOCKED_EN adds a registered locked output.
module bufr_mmcme #(
   parameter real DIVISOR = 16.0
) (
   input  logic clk,
   input  logic rst,
`ifdef BUFR_MMCME_LOCKED_EN
   output logic locked,
`endif
   output logic out
);

   localparam int N  = int'(DIVISOR);
   localparam int PW = (N < 2) ? 1 : $clog2(N);
   localparam logic [PW-1:0] LAST = PW'(N - 1);
   localparam logic [PW-1:0] HALF = PW'(N / 2);

   generate
      if (N < 2 || N > 128 || real'(N) != DIVISOR) begin : g_bad_divisor
         $error("bufr_mmcme: DIVISOR must be an integer value in 2..128");
      end
   endgenerate

   logic [PW-1:0] ph_reg = '0;
   logic [PW-1:0] ph_next;
   logic          run_reg = 1'b0;
   logic          run_next;
   logic          out_reg = 1'b0;
   logic          out_next;
   logic          wrap;

   // ph_next equals k mod N and run_next means k >= N for the edge being taken,
   // so at k=1 out_next is always 0 (run cannot be set before the first wrap).
   always_comb begin
      wrap     = (ph_reg == LAST);
      ph_next  = wrap ? '0 : ph_reg + 1'b1;
      run_next = run_reg | wrap;
      out_next = run_next && (ph_next < HALF);
   end

   // Toggling out while rst is held gives out-domain logic edges to reset on.
   always_ff @(posedge clk) begin
      if (rst) begin
         ph_reg  <= '0;
         run_reg <= 1'b0;
         out_reg <= ~out_reg;
      end else begin
         ph_reg  <= ph_next;
         run_reg <= run_next;
         out_reg <= out_next;
      end
   end

   assign out = out_reg;

`ifdef BUFR_MMCME_LOCKED_EN
   logic locked_reg = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         locked_reg <= 1'b0;
      end else begin
         locked_reg <= run_next;
      end
   end

   assign locked = locked_reg;
`endif

endmodule

// File: tb/tb_bufr_mmcme.sv
// Directed bench for bufr_mmcme: four dividers (16, 5, 2, 8) sharing one clock and reset.
module tb_bufr_mmcme;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic out16, out5, out2, out8;
`ifdef BUFR_MMCME_LOCKED_EN
   logic lock16, lock5, lock2, lock8;
`endif

   always #5 clk = ~clk;

`ifdef BUFR_MMCME_LOCKED_EN
   bufr_mmcme #(.DIVISOR(16.0)) u16 (.clk(clk), .rst(rst), .locked(lock16), .out(out16));
   bufr_mmcme #(.DIVISOR(5.0))  u5  (.clk(clk), .rst(rst), .locked(lock5),  .out(out5));
   bufr_mmcme #(.DIVISOR(2.0))  u2  (.clk(clk), .rst(rst), .locked(lock2),  .out(out2));
   bufr_mmcme #(.DIVISOR(8.0))  u8  (.clk(clk), .rst(rst), .locked(lock8),  .out(out8));
`else
   bufr_mmcme #(.DIVISOR(16.0)) u16 (.clk(clk), .rst(rst), .out(out16));
   bufr_mmcme #(.DIVISOR(5.0))  u5  (.clk(clk), .rst(rst), .out(out5));
   bufr_mmcme #(.DIVISOR(2.0))  u2  (.clk(clk), .rst(rst), .out(out2));
   bufr_mmcme #(.DIVISOR(8.0))  u8  (.clk(clk), .rst(rst), .out(out8));
`endif

   int passed = 0;
   int total  = 0;
   int k      = 0;
   int nval [4] = '{16, 5, 2, 8};
   logic [3:0] m_out  = 4'b0000;
   logic [3:0] m_lock = 4'b0000;
   logic       cnt_chk = 1'b0;
   logic [31:0] cnt_clk;
   logic [31:0] cnt_out;

   always @(posedge clk)   cnt_clk <= rst ? 32'd0 : cnt_clk + 32'd1;
   always @(posedge out16) cnt_out <= rst ? 32'd0 : cnt_out + 32'd1;

   function automatic logic exp_out(input int kk, input int n);
      return (kk >= n) && ((kk % n) < (n / 2));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
   endtask

   // Advance one clk edge, update the reference, sample 4 ns later, then set rst for the next edge.
   task automatic tick(input logic r);
      @(posedge clk);
      if (rst) begin
         k = 0;
         m_out  = ~m_out;
         m_lock = 4'b0000;
      end else begin
         k++;
         for (int i = 0; i < 4; i++) begin
            m_out[i]  = exp_out(k, nval[i]);
            m_lock[i] = (k >= nval[i]);
         end
      end
      #4;
      rst = r;
   endtask

   task automatic check_all();
      chk("out16", {31'd0, out16}, {31'd0, m_out[0]});
      chk("out5",  {31'd0, out5},  {31'd0, m_out[1]});
      chk("out2",  {31'd0, out2},  {31'd0, m_out[2]});
      chk("out8",  {31'd0, out8},  {31'd0, m_out[3]});
`ifdef BUFR_MMCME_LOCKED_EN
      chk("lock16", {31'd0, lock16}, {31'd0, m_lock[0]});
      chk("lock8",  {31'd0, lock8},  {31'd0, m_lock[3]});
`endif
      if (cnt_chk) chk("cnt_ratio", cnt_out, cnt_clk >> 4);
   endtask

   initial begin
      // Reset held for 5 edges: out toggles 1,0,1,0,1 from its initial 0.
      for (int i = 0; i < 5; i++) begin
         tick(i < 4);
         chk("rst_toggle16", {31'd0, out16}, {31'd0, (i % 2) == 0});
         chk("rst_toggle5",  {31'd0, out5},  {31'd0, (i % 2) == 0});
      end
      cnt_chk = 1'b1;

      for (int i = 1; i <= 4096; i++) begin
         tick(1'b0);
         check_all();
         case (k)
            1:  begin chk("n16_k1", {31'd0, out16}, 32'd0); chk("n2_k1", {31'd0, out2}, 32'd0); end
            2:  chk("n2_k2", {31'd0, out2}, 32'd1);
            3:  chk("n2_k3", {31'd0, out2}, 32'd0);
            4:  begin chk("n2_k4", {31'd0, out2}, 32'd1); chk("n5_k4", {31'd0, out5}, 32'd0); end
            5:  chk("n5_k5", {31'd0, out5}, 32'd1);
            6:  begin chk("n5_k6", {31'd0, out5}, 32'd1); chk("n2_k6", {31'd0, out2}, 32'd1); end
            7:  chk("n5_k7", {31'd0, out5}, 32'd0);
            9:  chk("n5_k9", {31'd0, out5}, 32'd0);
            10: chk("n5_k10", {31'd0, out5}, 32'd1);
            15: begin chk("n16_k15", {31'd0, out16}, 32'd0); chk("n5_k15", {31'd0, out5}, 32'd1); end
            16: chk("n16_k16", {31'd0, out16}, 32'd1);
            23: chk("n16_k23", {31'd0, out16}, 32'd1);
            24: chk("n16_k24", {31'd0, out16}, 32'd0);
            default: ;
         endcase
`ifdef BUFR_MMCME_LOCKED_EN
         if (k == 7) chk("lock8_k7", {31'd0, lock8}, 32'd0);
         if (k == 8) chk("lock8_k8", {31'd0, lock8}, 32'd1);
`endif
      end

      // Fresh reset, then a single-edge reset at k=37 in the middle of a high phase.
      cnt_chk = 1'b0;
      tick(1'b1);
      tick(1'b0);
      check_all();
      for (int i = 1; i <= 37; i++) begin
         tick(i == 36);
         check_all();
      end
      chk("midrst_k0", k, 32'd0);
      chk("midrst_out16", {31'd0, out16}, 32'd0);
`ifdef BUFR_MMCME_LOCKED_EN
      chk("midrst_lock8", {31'd0, lock8}, 32'd0);
`endif
      for (int i = 1; i <= 20; i++) begin
         tick(1'b0);
         check_all();
         if (k == 15) chk("midrst_k15", {31'd0, out16}, 32'd0);
         if (k == 16) chk("midrst_k16", {31'd0, out16}, 32'd1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
